// File: rtl/cfg_stream_loader.sv
// rtl/cfg_stream_loader.sv - buffered host-to-tile configuration bus loader
//
// Purpose: accepts {addr, data, last} words from the host over a valid/ready
// stream, buffers them in a DEPTH-entry FIFO and replays each word with a valid
// tile_id onto the shared config bus as a one-cycle strobe, followed by GAP idle
// cycles. Words whose tile_id (addr[ADDR_W-1:ADDR_W-8]) is 0 or above NUM_TILES
// are dropped and counted. Retiring a word marked last parks the loader in DONE
// until clear_done.
//
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   in_valid/in_ready/in_addr/in_data/in_last   host word stream
//   clear_done                         leaves DONE (ignored elsewhere)
//   config_addr/config_data/config_en  broadcast bus, qualified by config_en
//   busy, done                         status flags
//   word_count, err_count              saturating strobe / drop counters
//   checksum                           running XOR of issued data
//
// Optional feature: define CFG_CHECKSUM_EN to build the checksum register;
// otherwise checksum is tied to zero.
module cfg_stream_loader #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int NUM_TILES = 4,
  parameter int GAP       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              clear_done,
  output logic [ADDR_W-1:0] config_addr,
  output logic [DATA_W-1:0] config_data,
  output logic              config_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_count,
  output logic [7:0]        err_count,
  output logic [DATA_W-1:0] checksum
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [7:0] MAX_TILE = 8'(NUM_TILES);
  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);
  localparam bit GAP_ZERO = (GAP == 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_last [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, push, pop, pop_slot;
  logic [1:0]       state;
  logic [7:0]       gap_cnt;
  logic             cur_last;

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic [7:0]        head_tile;
  logic              head_ok;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign in_ready  = !full && (state != S_DONE);
  assign push      = in_valid && in_ready;
  assign busy      = !empty || (state == S_ISSUE) || (state == S_GAP);
  assign done      = (state == S_DONE);

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign head_last = mem_last[rd_ptr];
  assign head_tile = head_addr[ADDR_W-1 -: 8];
  assign head_ok   = (head_tile != 8'd0) && (head_tile <= MAX_TILE);

  // Cycles in which the head may be popped: IDLE, the strobe cycle itself when
  // there is no gap, and the final gap cycle. The pop in those last two slots
  // is what keeps strobes exactly GAP+1 cycles apart. After a last word the
  // loader heads for DONE instead of popping.
  always_comb begin
    pop_slot = 1'b0;
    case (state)
      S_IDLE:  pop_slot = 1'b1;
      S_ISSUE: pop_slot = GAP_ZERO && !cur_last;
      S_GAP:   pop_slot = (gap_cnt == 8'd0) && !cur_last;
      default: pop_slot = 1'b0;
    endcase
  end

  assign pop = pop_slot && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
      mem_last[wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      cur_last    <= 1'b0;
      config_en   <= 1'b0;
      config_addr <= '0;
      config_data <= '0;
      word_count  <= '0;
      err_count   <= '0;
    end else begin
      config_en <= 1'b0;
      case (state)
        S_ISSUE: begin
          if (!GAP_ZERO) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
          end else if (cur_last) begin
            state <= S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt != 8'd0)  gap_cnt <= gap_cnt - 8'd1;
          else if (cur_last)    state <= S_DONE;
          else                  state <= S_IDLE;
        end
        S_DONE: if (clear_done) state <= S_IDLE;
        default: ;
      endcase

      // A pop overrides the default next state chosen above.
      if (pop) begin
        if (head_ok) begin
          state       <= S_ISSUE;
          config_en   <= 1'b1;
          config_addr <= head_addr;
          config_data <= head_data;
          cur_last    <= head_last;
          if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
        end else begin
          // Dropped word: bus untouched, no gap.
          state <= head_last ? S_DONE : S_IDLE;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

`ifdef CFG_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                checksum <= '0;
    else if ((state == S_DONE) && clear_done)  checksum <= '0;
    else if (pop && head_ok)                   checksum <= checksum ^ head_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb/tb_cfg_stream_loader.sv - self-checking bench for cfg_stream_loader
//
// Three loaders run side by side on the same stimulus: GAP=1, GAP=0, GAP=3.
// A transaction-level model predicts every output each cycle; directed tests
// add literal expectations for latency, ordering, drops, DONE and reset.
module tb_cfg_stream_loader;

  localparam int NI    = 3;
  localparam int DEPTH = 4;
  localparam int NT    = 4;

`ifdef CFG_CHECKSUM_EN
  localparam logic [31:0] CK_PAIR = 32'hF00FF00F;
`else
  localparam logic [31:0] CK_PAIR = 32'h0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        l;
  } word_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_done = 1'b0;

  logic        iv [NI];
  logic        ir [NI];
  logic [31:0] ia [NI];
  logic [31:0] idt [NI];
  logic        il [NI];
  logic [31:0] ca [NI];
  logic [31:0] cd [NI];
  logic        en [NI];
  logic        bsy [NI];
  logic        dn [NI];
  logic [15:0] wc [NI];
  logic [7:0]  ec [NI];
  logic [31:0] ck [NI];

  always #5 clk = ~clk;

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cfg_stream_loader #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .NUM_TILES(NT),
      .GAP((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) dut (
      .clk(clk), .reset(reset),
      .in_valid(iv[g]), .in_ready(ir[g]), .in_addr(ia[g]), .in_data(idt[g]),
      .in_last(il[g]), .clear_done(clear_done),
      .config_addr(ca[g]), .config_data(cd[g]), .config_en(en[g]),
      .busy(bsy[g]), .done(dn[g]), .word_count(wc[g]), .err_count(ec[g]),
      .checksum(ck[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int          cyc;
  word_t       mq [NI][$];
  logic        m_en [NI];
  logic        m_done [NI];
  logic [31:0] m_a [NI];
  logic [31:0] m_d [NI];
  logic [31:0] m_ck [NI];
  int          m_wc [NI];
  int          m_ec [NI];
  int          free_at [NI];
  int          done_at [NI];
  int          busy_until [NI];
  bit          rdy;
  word_t       w;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        cyc = 0;
        for (int k = 0; k < NI; k++) begin
          mq[k].delete();
          m_en[k] = 0; m_done[k] = 0; m_a[k] = 0; m_d[k] = 0; m_ck[k] = 0;
          m_wc[k] = 0; m_ec[k] = 0;
          free_at[k] = 0; done_at[k] = -1; busy_until[k] = -1;
        end
      end else begin
        for (int k = 0; k < NI; k++) begin
          rdy = (mq[k].size() < DEPTH) && !m_done[k];
          m_en[k] = 0;
          if (m_done[k]) begin
            if (clear_done) begin
              m_done[k] = 0; m_ck[k] = 0; free_at[k] = cyc + 1;
            end
          end else if (done_at[k] == cyc + 1) begin
            m_done[k] = 1; done_at[k] = -1;
          end else if (done_at[k] < 0 && cyc >= free_at[k] && mq[k].size() > 0) begin
            w = mq[k].pop_front();
            if (int'(w.a[31:24]) != 0 && int'(w.a[31:24]) <= NT) begin
              m_en[k] = 1; m_a[k] = w.a; m_d[k] = w.d;
              if (m_wc[k] < 65535) m_wc[k]++;
`ifdef CFG_CHECKSUM_EN
              m_ck[k] = m_ck[k] ^ w.d;
`endif
              free_at[k]    = cyc + 1 + gap_of(k);
              busy_until[k] = cyc + 1 + gap_of(k);
              if (w.l) done_at[k] = cyc + 2 + gap_of(k);
            end else begin
              if (m_ec[k] < 255) m_ec[k]++;
              if (w.l) m_done[k] = 1;
              else     free_at[k] = cyc + 1;
            end
          end
          if (iv[k] && rdy) mq[k].push_back('{a: ia[k], d: idt[k], l: il[k]});
        end
        cyc++;
      end
    end
  end

  // ---------------- compare, log and feed ----------------
  word_t feed [NI][$];
  word_t fw;
  bit    acc [NI];
  bit    dn_prev [NI];
  bit    saw_full [NI];
  int    hs_cyc [NI];
  int    done_cyc [NI];
  int    st_cyc [NI][$];
  logic [31:0] st_data [NI][$];

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int k = 0; k < NI; k++) begin
          chk("config_en",   k, 64'(en[k]),  64'(m_en[k]));
          chk("config_addr", k, 64'(ca[k]),  64'(m_a[k]));
          chk("config_data", k, 64'(cd[k]),  64'(m_d[k]));
          chk("in_ready",    k, 64'(ir[k]),  64'((mq[k].size() < DEPTH) && !m_done[k]));
          chk("busy",        k, 64'(bsy[k]), 64'((mq[k].size() > 0) || (cyc <= busy_until[k])));
          chk("done",        k, 64'(dn[k]),  64'(m_done[k]));
          chk("word_count",  k, 64'(wc[k]),  64'(m_wc[k]));
          chk("err_count",   k, 64'(ec[k]),  64'(m_ec[k]));
          chk("checksum",    k, 64'(ck[k]),  64'(m_ck[k]));
          if (en[k]) begin
            st_cyc[k].push_back(cyc);
            st_data[k].push_back(cd[k]);
          end
          if (dn[k] && !dn_prev[k]) done_cyc[k] = cyc;
          dn_prev[k] = dn[k];
          if (acc[k] && feed[k].size() > 0) void'(feed[k].pop_front());
          if (feed[k].size() > 0) begin
            fw = feed[k][0];
            iv[k] = 1'b1; ia[k] = fw.a; idt[k] = fw.d; il[k] = fw.l;
          end else begin
            iv[k] = 1'b0;
          end
          acc[k] = iv[k] && ir[k];
          if (acc[k]) hs_cyc[k] = cyc;
          if (iv[k] && !ir[k] && !dn[k]) saw_full[k] = 1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic l);
    for (int k = 0; k < NI; k++) feed[k].push_back('{a: a, d: d, l: l});
  endtask

  task automatic clear_logs();
    for (int k = 0; k < NI; k++) begin
      st_cyc[k].delete(); st_data[k].delete(); saw_full[k] = 0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(dn[0] && dn[1] && dn[2]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < NI; k++) if (!dn[k]) chk("done_timeout", k, 64'(dn[k]), 64'd1);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear_done = 1'b1;
    @(negedge clk) clear_done = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run still active at t=%0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 0; ia[k] = 0; idt[k] = 0; il[k] = 0; acc[k] = 0; dn_prev[k] = 0;
      hs_cyc[k] = 0; done_cyc[k] = 0; saw_full[k] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready", k, 64'(ir[k]), 64'd1);
      chk("rst_busy",     k, 64'(bsy[k]), 64'd0);
      chk("rst_addr",     k, 64'(ca[k]), 64'd0);
      chk("rst_wc",       k, 64'(wc[k]), 64'd0);
    end

    // Single word: strobe two cycles after handshake, done GAP+1 after strobe.
    clear_logs();
    send(32'h0200_0010, 32'hDEAD_BEEF, 1'b1);
    wait_done(200);
    for (int k = 0; k < NI; k++) begin
      chk("t1_nstrobe", k, 64'(st_cyc[k].size()), 64'd1);
      if (st_cyc[k].size() > 0) begin
        chk("t1_latency",   k, 64'(st_cyc[k][0] - hs_cyc[k]), 64'd2);
        chk("t1_done_lag",  k, 64'(done_cyc[k] - st_cyc[k][0]), 64'(gap_of(k) + 1));
      end
      chk("t1_addr", k, 64'(ca[k]), 64'h0200_0010);
      chk("t1_data", k, 64'(cd[k]), 64'hDEAD_BEEF);
      chk("t1_wc",   k, 64'(wc[k]), 64'd1);
    end
    pulse_clear();
    for (int k = 0; k < NI; k++) begin
      chk("t1_cleared", k, 64'(dn[k]), 64'd0);
      chk("t1_wc_kept", k, 64'(wc[k]), 64'd1);
    end

    // Six back-to-back words, tiles 1..4 cycling.
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      a = {8'(i % 4 + 1), 24'(i)};
      send(a, 32'h1000 + 32'(i), i == 5);
    end
    wait_done(400);
    for (int k = 0; k < NI; k++) begin
      chk("t2_nstrobe", k, 64'(st_data[k].size()), 64'd6);
      if (st_data[k].size() == 6) begin
        for (int i = 0; i < 6; i++) chk("t2_order", k, 64'(st_data[k][i]), 64'h1000 + 64'(i));
        chk("t2_span", k, 64'(st_cyc[k][5] - st_cyc[k][0]), 64'(5 * (gap_of(k) + 1)));
      end
      chk("t2_wc", k, 64'(wc[k]), 64'd7);
    end
    chk("t2_full_seen", 2, 64'(saw_full[2]), 64'd1);
    pulse_clear();

    // Bad tile_ids 0 and 5, the second marked last.
    clear_logs();
    send(32'h0000_0004, 32'hBAD0, 1'b0);
    send(32'h0500_0000, 32'hBAD1, 1'b1);
    wait_done(200);
    for (int k = 0; k < NI; k++) begin
      chk("t3_err",     k, 64'(ec[k]), 64'd2);
      chk("t3_nstrobe", k, 64'(st_cyc[k].size()), 64'd0);
      chk("t3_addr",    k, 64'(ca[k]), 64'h0200_0005);
      chk("t3_data",    k, 64'(cd[k]), 64'h1005);
    end
    pulse_clear();

    // Checksum pair, then a word offered while in DONE.
    send(32'h0100_0000, 32'h0F0F_0F0F, 1'b0);
    send(32'h0200_0000, 32'hFF00_FF00, 1'b1);
    wait_done(200);
    for (int k = 0; k < NI; k++) chk("t4_checksum", k, 64'(ck[k]), 64'(CK_PAIR));
    send(32'h0300_0000, 32'h1234_5678, 1'b1);
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("t5_ready_low", k, 64'(ir[k]), 64'd0);
        chk("t5_wc_hold",   k, 64'(wc[k]), 64'd9);
      end
    end
    pulse_clear();
    for (int k = 0; k < NI; k++) chk("t5_ck_clear", k, 64'(ck[k]), 64'd0);
    wait_done(200);
    for (int k = 0; k < NI; k++) begin
      chk("t5_wc",   k, 64'(wc[k]), 64'd10);
      chk("t5_data", k, 64'(cd[k]), 64'h1234_5678);
    end
    pulse_clear();

    // Reset during the gap after word 2 of 4 on the GAP=1 loader.
    for (int i = 0; i < 4; i++) send({8'(i + 1), 24'h0}, 32'h2000 + 32'(i), i == 3);
    n = 0;
    for (int t = 0; t < 100 && n < 2; t++) begin
      @(negedge clk);
      if (en[0]) n++;
    end
    chk("t6_two_strobes", 0, 64'(n), 64'd2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      feed[k].delete();
      acc[k] = 0;
      dn_prev[k] = 0;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("t6_rst_en",    k, 64'(en[k]), 64'd0);
      chk("t6_rst_addr",  k, 64'(ca[k]), 64'd0);
      chk("t6_rst_data",  k, 64'(cd[k]), 64'd0);
      chk("t6_rst_wc",    k, 64'(wc[k]), 64'd0);
      chk("t6_rst_busy",  k, 64'(bsy[k]), 64'd0);
      chk("t6_rst_ready", k, 64'(ir[k]), 64'd1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
    send(32'h0400_0042, 32'hCAFE_F00D, 1'b1);
    wait_done(200);
    for (int k = 0; k < NI; k++) begin
      chk("t6_wc",   k, 64'(wc[k]), 64'd1);
      chk("t6_data", k, 64'(cd[k]), 64'hCAFE_F00D);
      chk("t6_err",  k, 64'(ec[k]), 64'd0);
    end
    pulse_clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
